// File: rtl/fifo_rr_reader.sv
// Round-robin scheduler that drains a bank of show-ahead FIFOs into one registered valid/ready stream.
// A channel keeps the grant for at most BURST_LEN consecutive pops while other channels are waiting.
module fifo_rr_reader #(
    parameter int NUM_CH    = 4,
    parameter int DWIDTH    = 8,
    parameter int BURST_LEN = 4,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [NUM_CH-1:0]        empty_i,
    input  logic [NUM_CH*DWIDTH-1:0] q_i,
    output logic [NUM_CH-1:0]        rdreq_o,
    output logic [DWIDTH-1:0]        data_o,
    output logic [CH_W-1:0]          ch_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     busy_o
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CH_W-1:0]      r_cur;
    logic [CNT_W-1:0]     r_cnt;
    logic [DWIDTH-1:0]    r_data;
    logic [CH_W-1:0]      r_ch;
    logic                 r_valid;

    logic [DWIDTH-1:0]    w_q [NUM_CH];
    logic                 w_stay;
    logic                 w_rot_found;
    logic [CH_W-1:0]      w_rot_ch;
    logic [CH_W-1:0]      w_scan;
    logic                 w_have_sel;
    logic [CH_W-1:0]      w_sel;
    logic                 w_load;
    logic                 w_drain;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_q[g]     = q_i[g*DWIDTH +: DWIDTH];
            assign rdreq_o[g] = w_load && (w_sel == CH_W'(g));
        end
    endgenerate

    // Stay on the current channel only while its burst budget lasts.
    assign w_stay = (r_state == S_BURST) && (r_cnt < CNT_W'(BURST_LEN)) && !empty_i[r_cur];

    always_comb begin
        w_rot_found = 1'b0;
        w_rot_ch    = '0;
        w_scan      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_scan = CH_W'((int'(r_cur) + i) % NUM_CH);
            if (!w_rot_found && !empty_i[w_scan]) begin
                w_rot_found = 1'b1;
                w_rot_ch    = w_scan;
            end
        end
    end

    assign w_have_sel = w_stay || w_rot_found;
    assign w_sel      = w_stay ? r_cur : w_rot_ch;
    assign w_load     = (!r_valid || ready_i) && w_have_sel && !srst_i;
    assign w_drain    = r_valid && ready_i && !w_have_sel;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = S_BURST;
        end else if (w_drain) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        busy_o = (r_state == S_BURST);
    end

    // A rotate that lands back on the current channel starts a fresh burst.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_cur   <= CH_W'(NUM_CH - 1);
            r_cnt   <= '0;
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_q[w_sel];
            r_ch    <= w_sel;
            r_valid <= 1'b1;
            if (w_stay) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cur <= w_sel;
                r_cnt <= CNT_W'(1);
            end
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign data_o  = r_data;
    assign ch_o    = r_ch;
    assign valid_o = r_valid;

endmodule

// File: tb/tb_fifo_rr_reader.sv
// Directed bench for fifo_rr_reader with four behavioural show-ahead FIFOs feeding it.
module tb_fifo_rr_reader;

    logic        clk;
    logic        srst;
    logic [3:0]  empty;
    logic [31:0] q;
    logic [3:0]  rdreq;
    logic [7:0]  data;
    logic [1:0]  ch;
    logic        valid;
    logic        ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [4][16];
    logic [3:0] wp [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] rp [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

    logic [7:0] exp_d [8];
    logic [1:0] exp_c [8];

    fifo_rr_reader #(
        .NUM_CH    (4),
        .DWIDTH    (8),
        .BURST_LEN (2)
    ) dut (
        .clk_i   (clk),
        .srst_i  (srst),
        .empty_i (empty),
        .q_i     (q),
        .rdreq_o (rdreq),
        .data_o  (data),
        .ch_o    (ch),
        .valid_o (valid),
        .ready_i (ready),
        .busy_o  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_fifo
            assign empty[g]       = (wp[g] == rp[g]);
            assign q[g*8 +: 8]    = mem[g][rp[g]];
            always @(posedge clk) begin
                if (rdreq[g]) rp[g] <= rp[g] + 4'd1;
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int c, input logic [7:0] d);
        mem[c][wp[c]] = d;
        wp[c] = wp[c] + 4'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 16; a++)
                mem[c][a] = 8'h00;
        exp_d = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
        exp_c = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        srst  = 1'b1;
        ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_ch", ch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdreq", rdreq, 0);
        srst = 1'b0;

        // Single channel: three words in ch2.
        push(2, 8'hA1); push(2, 8'hB2); push(2, 8'hC3);
        #1;
        chk("single_rdreq0", rdreq, 4'b0100);
        tick();
        chk("single_d0", data, 8'hA1);
        chk("single_c0", ch, 2);
        chk("single_v0", valid, 1);
        chk("single_busy0", busy, 1);
        chk("single_rdreq1", rdreq, 4'b0100);
        tick();
        chk("single_d1", data, 8'hB2);
        chk("single_rdreq2", rdreq, 4'b0100);
        tick();
        chk("single_d2", data, 8'hC3);
        chk("single_c2", ch, 2);
        chk("single_rdreq3", rdreq, 0);
        tick();
        chk("single_v_end", valid, 0);
        chk("single_busy_end", busy, 0);

        // Burst limit and fairness between ch0 and ch1.
        for (int i = 0; i < 4; i++) begin
            push(0, 8'h10 + 8'(i));
            push(1, 8'h20 + 8'(i));
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("fair_ch%0d", i), ch, exp_c[i]);
            chk($sformatf("fair_d%0d", i), data, exp_d[i]);
            chk($sformatf("fair_v%0d", i), valid, 1);
        end
        tick();
        chk("fair_v_end", valid, 0);

        // Backpressure on ch3.
        push(3, 8'h31); push(3, 8'h32); push(3, 8'h33);
        #1;
        chk("bp_rdreq0", rdreq, 4'b1000);
        tick();
        chk("bp_d0", data, 8'h31);
        ready = 1'b0;
        #1;
        chk("bp_rdreq_hold", rdreq, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold_d%0d", i), data, 8'h31);
            chk($sformatf("bp_hold_c%0d", i), ch, 3);
            chk($sformatf("bp_hold_v%0d", i), valid, 1);
            chk($sformatf("bp_hold_rdreq%0d", i), rdreq, 0);
        end
        ready = 1'b1;
        #1;
        chk("bp_rdreq_resume", rdreq, 4'b1000);
        tick();
        chk("bp_d1", data, 8'h32);
        chk("bp_v1", valid, 1);
        tick();
        chk("bp_d2", data, 8'h33);
        chk("bp_c2", ch, 3);
        tick();
        chk("bp_v_end", valid, 0);

        // Wrap-around from ch3 to ch0, then ch2.
        push(0, 8'h40); push(2, 8'h42);
        #1;
        chk("wrap_rdreq0", rdreq, 4'b0001);
        tick();
        chk("wrap_d0", data, 8'h40);
        chk("wrap_c0", ch, 0);
        chk("wrap_rdreq1", rdreq, 4'b0100);
        tick();
        chk("wrap_d1", data, 8'h42);
        chk("wrap_c1", ch, 2);
        tick();
        chk("wrap_v_end", valid, 0);

        // Reset in the middle of a burst.
        push(1, 8'h51); push(1, 8'h52); push(3, 8'h53);
        #1;
        chk("rstmid_rdreq0", rdreq, 4'b1000);
        tick();
        chk("rstmid_d0", data, 8'h53);
        chk("rstmid_v0", valid, 1);
        srst = 1'b1;
        #1;
        chk("rstmid_rdreq_rst", rdreq, 0);
        tick();
        chk("rstmid_v", valid, 0);
        chk("rstmid_data", data, 0);
        chk("rstmid_busy", busy, 0);
        srst = 1'b0;
        #1;
        chk("rstmid_rdreq_after", rdreq, 4'b0010);
        tick();
        chk("rstmid_d1", data, 8'h51);
        chk("rstmid_c1", ch, 1);
        tick();
        chk("rstmid_d2", data, 8'h52);
        tick();
        chk("rstmid_v_end", valid, 0);

        // Idle with every FIFO empty, then one word on ch1.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_rdreq%0d", i), rdreq, 0);
            chk($sformatf("idle_v%0d", i), valid, 0);
        end
        push(1, 8'h61);
        #1;
        chk("idle_rdreq_word", rdreq, 4'b0010);
        tick();
        chk("idle_d", data, 8'h61);
        chk("idle_c", ch, 1);
        chk("idle_v", valid, 1);
        tick();
        chk("idle_v_end", valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
